// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: initiator-side request controller for the mem_system port.
// Buffers up to DEPTH word requests, issues them one at a time on Rd/Wr/Addr/DataIn,
// holds them until Done (or the watchdog expires) and returns the result on a
// valid/ready response channel.
// Optional feature: define MEM_REQ_CTRL_STATS_EN to add the stat_access / stat_hit
// completion counters.
module mem_req_ctrl #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  // response channel
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_rdata,
  output logic        resp_hit,
  output logic [1:0]  resp_err,
  // mem_system port
  output logic [15:0] Addr,
  output logic [15:0] DataIn,
  output logic        Rd,
  output logic        Wr,
  input  logic [15:0] DataOut,
  input  logic        Done,
  input  logic        Stall,
  input  logic        CacheHit
`ifdef MEM_REQ_CTRL_STATS_EN
  ,
  output logic [15:0] stat_access,
  output logic [15:0] stat_hit
`endif
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [WdW-1:0]  WdMax   = WdW'(TIMEOUT);
  localparam logic [WdW-1:0]  WdLast  = WdW'(TIMEOUT - 1);

  localparam logic [1:0] ErrOk      = 2'b00;
  localparam logic [1:0] ErrAlign   = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  // Stall carries no information we act on: the request is held stable regardless.
  logic unused_stall;
  assign unused_stall = Stall;

  // ---------------------------------------------------------------------------
  // Request queue
  // ---------------------------------------------------------------------------
  logic            q_wr    [DEPTH];
  logic [15:0]     q_addr  [DEPTH];
  logic [15:0]     q_wdata [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            push, pop;

  state_e          state_q, state_d;

  // req_ready comes straight from a flop so Done never reaches it combinationally.
  assign req_ready = ~full_q;
  assign push      = req_valid & ~full_q;
  assign pop       = (state_q == StIdle) && (cnt_q != '0);

  // Queue storage; payload needs no reset, occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) begin
      q_wr[wr_ptr_q]    <= req_wr;
      q_addr[wr_ptr_q]  <= req_addr;
      q_wdata[wr_ptr_q] <= req_wdata;
    end
  end

  // Queue pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    full_d = (cnt_d == CntFull);
  end

  // Queue pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= full_d;
    end
  end

  logic        head_wr;
  logic [15:0] head_addr;
  logic [15:0] head_wdata;
  assign head_wr    = q_wr[rd_ptr_q];
  assign head_addr  = q_addr[rd_ptr_q];
  assign head_wdata = q_wdata[rd_ptr_q];

  // ---------------------------------------------------------------------------
  // Issue / response FSM
  // ---------------------------------------------------------------------------
  logic           rd_q, rd_d;
  logic           wr_q, wr_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    din_q, din_d;
  logic [WdW-1:0] wdog_q, wdog_d;
  logic [15:0]    rdata_q, rdata_d;
  logic           hit_q, hit_d;
  logic [1:0]     err_q, err_d;

  // Next state, memory-port drive and response capture.
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    wdog_d  = wdog_q;
    rdata_d = rdata_q;
    hit_d   = hit_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          if (head_addr[0]) begin
            // Odd address: complete with an error without touching memory.
            rdata_d = '0;
            hit_d   = 1'b0;
            err_d   = ErrAlign;
            state_d = StResp;
          end else begin
            addr_d  = head_addr;
            din_d   = head_wdata;
            rd_d    = ~head_wr;
            wr_d    = head_wr;
            wdog_d  = '0;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (wdog_q != WdMax) wdog_d = wdog_q + WdW'(1);
        // Done takes priority over a simultaneous watchdog expiry.
        if (Done) begin
          rdata_d = wr_q ? 16'h0000 : DataOut;
          hit_d   = CacheHit;
          err_d   = ErrOk;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StResp;
        end else if (wdog_q >= WdLast) begin
          rdata_d = '0;
          hit_d   = 1'b0;
          err_d   = ErrTimeout;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  // FSM and memory-port registers; reset drops Rd/Wr asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      wdog_q  <= '0;
      rdata_q <= '0;
      hit_q   <= 1'b0;
      err_q   <= ErrOk;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      wdog_q  <= wdog_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
    end
  end

  assign Rd         = rd_q;
  assign Wr         = wr_q;
  assign Addr       = addr_q;
  assign DataIn     = din_q;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_hit   = hit_q;
  assign resp_err   = err_q;

`ifdef MEM_REQ_CTRL_STATS_EN
  // ---------------------------------------------------------------------------
  // Completion statistics (errors are not counted)
  // ---------------------------------------------------------------------------
  logic [15:0] stat_access_q;
  logic [15:0] stat_hit_q;
  logic        done_evt;
  assign done_evt = (state_q == StIssue) && Done;

  // Saturating counters of completed accesses and cache hits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_access_q <= '0;
      stat_hit_q    <= '0;
    end else begin
      if (done_evt && (stat_access_q != 16'hFFFF)) stat_access_q <= stat_access_q + 16'd1;
      if (done_evt && CacheHit && (stat_hit_q != 16'hFFFF)) stat_hit_q <= stat_hit_q + 16'd1;
    end
  end

  assign stat_access = stat_access_q;
  assign stat_hit    = stat_hit_q;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: directed requests push expected responses and
// expected memory accesses; independent monitors compare what the DUT presents.
module tb_mem_req_ctrl;

  typedef struct packed {
    logic [15:0] rdata;
    logic        hit;
    logic [1:0]  err;
  } resp_t;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    int unsigned cycles;
  } acc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [15:0] resp_rdata;
  logic        resp_hit;
  logic [1:0]  resp_err;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut = '0;
  logic        Done;
  logic        done_mem = 1'b0;
  logic        done_x = 1'b0;
  logic        Stall = 1'b0;
  logic        CacheHit = 1'b0;
`ifdef MEM_REQ_CTRL_STATS_EN
  logic [15:0] stat_access;
  logic [15:0] stat_hit;
`endif

  assign Done = done_mem | done_x;

  mem_req_ctrl #(
    .DEPTH  (2),
    .TIMEOUT(64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_hit  (resp_hit),
    .resp_err  (resp_err),
    .Addr      (Addr),
    .DataIn    (DataIn),
    .Rd        (Rd),
    .Wr        (Wr),
    .DataOut   (DataOut),
    .Done      (Done),
    .Stall     (Stall),
    .CacheHit  (CacheHit)
`ifdef MEM_REQ_CTRL_STATS_EN
    ,
    .stat_access(stat_access),
    .stat_hit   (stat_hit)
`endif
  );

  always #5 clk = ~clk;

  resp_t exp_q[$];
  acc_t  acc_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Memory model: Done in the mem_lat-th cycle of an access; writes stored, reads
  // return stored data or mem_dflt.
  logic [15:0] mem [logic [15:0]];
  int unsigned mem_lat  = 1;
  logic        mem_en   = 1'b1;
  logic        mem_hit  = 1'b0;
  logic [15:0] mem_dflt = 16'h0000;
  int unsigned busy     = 0;

  initial forever begin
    @(negedge clk);
    if (!rst_n || !(Rd || Wr)) begin
      busy     = 0;
      done_mem = 1'b0;
      Stall    = 1'b0;
    end else begin
      busy++;
      if (mem_en && busy == mem_lat) begin
        done_mem = 1'b1;
        Stall    = 1'b0;
        CacheHit = mem_hit;
        if (Wr) begin
          mem[Addr] = DataIn;
          DataOut   = 16'hFFFF;
        end else begin
          DataOut = mem.exists(Addr) ? mem[Addr] : mem_dflt;
        end
      end else begin
        done_mem = 1'b0;
        Stall    = 1'b1;
      end
    end
  end

  // Access monitor: exclusivity, stability while active, and access log vs expected.
  acc_t cur;
  acc_t ea_m;
  logic act = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      act = 1'b0;
      exp_q.delete();
      acc_q.delete();
    end else begin
      chk("rd_wr_exclusive", 32'(Rd & Wr), 32'd0);
      if (Rd || Wr) begin
        if (!act) begin
          act        = 1'b1;
          cur.wr     = Wr;
          cur.addr   = Addr;
          cur.data   = DataIn;
          cur.cycles = 1;
        end else begin
          cur.cycles++;
          chk("bus_addr_stable", 32'(Addr), 32'(cur.addr));
          chk("bus_ctl_stable", 32'({Wr, DataIn}), 32'({cur.wr, cur.data}));
        end
      end else if (act) begin
        act = 1'b0;
        if (acc_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_access: got addr 0x%0h wr %0b, expected none", cur.addr,
                   cur.wr);
        end else begin
          ea_m = acc_q.pop_front();
          chk("acc_wr", 32'(cur.wr), 32'(ea_m.wr));
          chk("acc_addr", 32'(cur.addr), 32'(ea_m.addr));
          if (ea_m.wr) chk("acc_wdata", 32'(cur.data), 32'(ea_m.data));
          chk("acc_cycles", cur.cycles, ea_m.cycles);
        end
      end
    end
  end

  // Response monitor: compare every handshake against the scoreboard head.
  resp_t er_m;
  initial forever begin
    @(negedge clk);
    if (rst_n && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got rdata 0x%0h err %0d, expected none", resp_rdata,
                 resp_err);
      end else begin
        er_m = exp_q.pop_front();
        chk("resp_rdata", 32'(resp_rdata), 32'(er_m.rdata));
        chk("resp_hit", 32'(resp_hit), 32'(er_m.hit));
        chk("resp_err", 32'(resp_err), 32'(er_m.err));
      end
    end
  end

  // Present one request, wait (bounded) for acceptance, record expectations.
  task automatic req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                     input logic [15:0] e_rdata, input logic e_hit, input logic [1:0] e_err,
                     input int unsigned cycles);
    resp_t er;
    acc_t  ea;
    bit    ok = 1'b0;
    er.rdata  = e_rdata;
    er.hit    = e_hit;
    er.err    = e_err;
    ea.wr     = wr;
    ea.addr   = addr;
    ea.data   = wdata;
    ea.cycles = cycles;
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_wdata = wdata;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL push_timeout: got req_ready 0, expected 1 within 300 cycles");
    end else begin
      @(posedge clk);
      exp_q.push_back(er);
      if (cycles != 0) acc_q.push_back(ea);
    end
    #1;
    req_valid = 1'b0;
  endtask

  // Bounded wait until all expected traffic has been seen and the DUT is quiet.
  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && acc_q.size() == 0 && !resp_valid && !Rd && !Wr) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp_valid();
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("resp_valid_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_resp_hit", 32'(resp_hit), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_addr", 32'(Addr), 32'd0);
    chk("rst_datain", 32'(DataIn), 32'd0);
    chk("rst_rd", 32'(Rd), 32'd0);
    chk("rst_wr", 32'(Wr), 32'd0);
    @(posedge clk);
    #1;

    // Read 0x0010, Done after 4 cycles, DataOut 0xBEEF, miss; response held until ready.
    mem_dflt   = 16'hBEEF;
    mem_hit    = 1'b0;
    mem_lat    = 4;
    resp_ready = 1'b0;
    req(1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 2'b00, 4);
    @(negedge clk);
    chk("t1_rd_n1", 32'(Rd), 32'd0);
    @(negedge clk);
    chk("t1_rd_n2", 32'(Rd), 32'd1);
    chk("t1_addr", 32'(Addr), 32'h0010);
    wait_resp_valid();
    repeat (3) @(negedge clk);
    chk("t1_hold_valid", 32'(resp_valid), 32'd1);
    chk("t1_hold_rdata", 32'(resp_rdata), 32'hBEEF);
    chk("t1_hold_rd", 32'(Rd), 32'd0);
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_drain();

    // Write then read back-to-back, Done after 1 cycle, hits.
    mem_lat = 1;
    mem_hit = 1'b1;
    req(1'b1, 16'h0020, 16'h1234, 16'h0000, 1'b1, 2'b00, 1);
    req(1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b1, 2'b00, 1);
    wait_drain();

    // Queue fills while the first access stalls; fourth waits for a free slot.
    mem_lat  = 6;
    mem_hit  = 1'b0;
    mem_dflt = 16'h5A5A;
    req(1'b0, 16'h0100, 16'h0000, 16'h5A5A, 1'b0, 2'b00, 6);
    req(1'b1, 16'h0102, 16'hCAFE, 16'h0000, 1'b0, 2'b00, 6);
    req(1'b0, 16'h0102, 16'h0000, 16'hCAFE, 1'b0, 2'b00, 6);
    @(negedge clk);
    chk("t3_full_ready", 32'(req_ready), 32'd0);
    chk("t3_first_active", 32'(Rd), 32'd1);
    @(posedge clk);
    #1;
    req(1'b0, 16'h0104, 16'h0000, 16'h5A5A, 1'b0, 2'b00, 6);
    wait_drain();

    // Misaligned read: error response two cycles after acceptance, no access.
    req(1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b0, 2'b01, 0);
    @(negedge clk);
    chk("t4_valid_n1", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("t4_valid_n2", 32'(resp_valid), 32'd1);
    wait_drain();

    // Watchdog: no Done, Rd held 64 cycles, timeout error; a late Done is ignored.
    mem_en = 1'b0;
    req(1'b0, 16'h0040, 16'h0000, 16'h0000, 1'b0, 2'b10, 64);
    wait_drain();
    done_x = 1'b1;
    repeat (2) @(posedge clk);
    #1 done_x = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_late_done_valid", 32'(resp_valid), 32'd0);
    chk("t5_late_done_rd", 32'(Rd), 32'd0);
    @(posedge clk);
    #1;

    // Reset while Rd is active and the queue is full.
    req(1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b0, 2'b00, 1);
    req(1'b0, 16'h0202, 16'h0000, 16'h0000, 1'b0, 2'b00, 1);
    req(1'b0, 16'h0204, 16'h0000, 16'h0000, 1'b0, 2'b00, 1);
    @(negedge clk);
    chk("t6_pre_rd", 32'(Rd), 32'd1);
    chk("t6_pre_ready", 32'(req_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rd", 32'(Rd), 32'd0);
    chk("t6_rst_ready", 32'(req_ready), 32'd1);
    chk("t6_rst_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_en = 1'b1;
    @(posedge clk);
    #1;

    // Ten completed reads, six of them hits.
    mem_lat = 1;
    for (int i = 0; i < 10; i++) begin
      mem_hit = (i == 0 || i == 1 || i == 3 || i == 4 || i == 6 || i == 8);
      req(1'b0, 16'h0300 + 16'(2 * i), 16'h0000, 16'h5A5A, mem_hit, 2'b00, 1);
      wait_drain();
    end
`ifdef MEM_REQ_CTRL_STATS_EN
    chk("stat_access", 32'(stat_access), 32'd10);
    chk("stat_hit", 32'(stat_hit), 32'd6);
`endif
    chk("end_exp_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
